// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: answers VGA writer requests with one ZBT word from the displayed frame buffer.
module vga_pixel_fetch #(
   parameter int MEM_W           = 36,
   parameter int ADDR_W          = 19,
   parameter int WORDS_PER_FRAME = 153600,
   parameter int BASE_0          = 0,
   parameter int BASE_1          = 153600,
   parameter int READ_LAT        = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              vga_flag,
   input  logic              pixel_active,
   input  logic              frame_start,
   input  logic              frame_flag,
   output logic [MEM_W-1:0]  vga_pixel,
   output logic              done_vga,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_grant,
   input  logic [MEM_W-1:0]  mem_rdata,
   output logic              buf_sel,
   output logic              underrun
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, BLANK} state_t;
   localparam logic [ADDR_W-1:0] B0 = ADDR_W'(BASE_0);
   localparam logic [ADDR_W-1:0] B1 = ADDR_W'(BASE_1);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS_PER_FRAME - 1);
   localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);
   state_t state_q, state_d;
   logic [ADDR_W-1:0] offset_q, offset_d, mem_addr_q, mem_addr_d;
   logic [MEM_W-1:0] vga_pixel_q, vga_pixel_d;
   logic [1:0] lat_q, lat_d;
   logic done_vga_q, done_vga_d, mem_req_q, mem_req_d;
   logic buf_sel_q, buf_sel_d, underrun_q, underrun_d, swap_pending_q, swap_pending_d;
   always_comb begin
      state_d        = state_q;
      offset_d       = offset_q;
      mem_addr_d     = mem_addr_q;
      vga_pixel_d    = vga_pixel_q;
      lat_d          = lat_q;
      mem_req_d      = mem_req_q;
      done_vga_d     = 1'b0;
      buf_sel_d      = buf_sel_q;
      underrun_d     = underrun_q | (vga_flag & (state_q != IDLE));
      swap_pending_d = swap_pending_q | frame_flag;
      case (state_q)
         IDLE: if (vga_flag) begin
            state_d    = pixel_active ? REQ : BLANK;
            mem_req_d  = pixel_active;
            mem_addr_d = pixel_active ? (buf_sel_q ? B1 : B0) + offset_q : mem_addr_q;
         end
         REQ: if (mem_grant) begin
            mem_req_d = 1'b0;
            lat_d     = LAT_INIT;
            state_d   = WAIT;
         end
         WAIT: if (lat_q == 2'd0) begin
            vga_pixel_d = mem_rdata;
            done_vga_d  = 1'b1;
            offset_d    = (offset_q == LAST) ? '0 : offset_q + 1'b1;
            state_d     = IDLE;
         end else begin
            lat_d = lat_q - 2'd1;
         end
         BLANK: begin
            vga_pixel_d = '0;
            done_vga_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
      // swapping only here keeps a frame from mixing two buffers
      if (frame_start) begin
         offset_d       = '0;
         buf_sel_d      = buf_sel_q ^ swap_pending_d;
         swap_pending_d = 1'b0;
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         offset_q       <= '0;
         mem_addr_q     <= '0;
         vga_pixel_q    <= '0;
         lat_q          <= '0;
         mem_req_q      <= 1'b0;
         done_vga_q     <= 1'b0;
         buf_sel_q      <= 1'b0;
         underrun_q     <= 1'b0;
         swap_pending_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         offset_q       <= offset_d;
         mem_addr_q     <= mem_addr_d;
         vga_pixel_q    <= vga_pixel_d;
         lat_q          <= lat_d;
         mem_req_q      <= mem_req_d;
         done_vga_q     <= done_vga_d;
         buf_sel_q      <= buf_sel_d;
         underrun_q     <= underrun_d;
         swap_pending_q <= swap_pending_d;
      end
   end
   assign vga_pixel = vga_pixel_q;
   assign done_vga  = done_vga_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign buf_sel   = buf_sel_q;
   assign underrun  = underrun_q;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: directed checks of fetch timing, grant stall, wrap, buffer swap, blank, underrun, reset.
module tb_vga_pixel_fetch;
   logic clock = 1'b0;
   logic reset, vga_flag, pixel_active, frame_start, frame_flag, mem_grant;
   logic [35:0] mem_rdata, vga_pixel;
   logic [18:0] mem_addr;
   logic done_vga, mem_req, buf_sel, underrun;
   int n_checks = 0;
   int n_fail = 0;
   vga_pixel_fetch #(.WORDS_PER_FRAME(8)) dut (
      .clock(clock), .reset(reset), .vga_flag(vga_flag), .pixel_active(pixel_active),
      .frame_start(frame_start), .frame_flag(frame_flag), .vga_pixel(vga_pixel),
      .done_vga(done_vga), .mem_req(mem_req), .mem_addr(mem_addr), .mem_grant(mem_grant),
      .mem_rdata(mem_rdata), .buf_sel(buf_sel), .underrun(underrun)
   );
   always #5 clock = ~clock;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic fetch(input logic [18:0] a, input logic [35:0] d);
      vga_flag = 1; pixel_active = 1; mem_grant = 1; mem_rdata = d;
      step();
      vga_flag = 0;
      check("fetch_req", mem_req, 1);
      check("fetch_addr", mem_addr, a);
      step();
      check("fetch_req_drop", mem_req, 0);
      step();
      check("fetch_done_early", done_vga, 0);
      step();
      check("fetch_done", done_vga, 1);
      check("fetch_pixel", vga_pixel, d);
      step();
      check("fetch_done_clear", done_vga, 0);
   endtask
   initial begin
      reset = 1; vga_flag = 0; pixel_active = 0; frame_start = 0; frame_flag = 0;
      mem_grant = 0; mem_rdata = '0;
      step(); step();
      reset = 0;
      check("rst_pixel", vga_pixel, 0);
      check("rst_done", done_vga, 0);
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_buf", buf_sel, 0);
      check("rst_underrun", underrun, 0);
      fetch(19'd0, 36'h123456789);
      // grant withheld for five cycles
      vga_flag = 1; pixel_active = 1; mem_grant = 0;
      step();
      vga_flag = 0;
      for (int i = 0; i < 5; i++) begin
         check("stall_req", mem_req, 1);
         check("stall_addr", mem_addr, 1);
         step();
      end
      mem_grant = 1; mem_rdata = 36'hABCDEF012;
      check("stall_req_last", mem_req, 1);
      step();
      check("stall_req_drop", mem_req, 0);
      step();
      check("stall_done_early", done_vga, 0);
      step();
      check("stall_done", done_vga, 1);
      check("stall_pixel", vga_pixel, 36'hABCDEF012);
      step();
      for (int i = 2; i < 8; i++) fetch(19'(i), 36'(i * 17));
      fetch(19'd0, 36'h0F0F0F0F0);
      // frame_start alone: offset back to 0, buffer unchanged
      frame_start = 1; step(); frame_start = 0;
      check("fs_alone_buf", buf_sel, 0);
      fetch(19'd0, 36'h111111111);
      frame_flag = 1; step(); frame_flag = 0;
      check("ff_no_swap_yet", buf_sel, 0);
      frame_start = 1; step(); frame_start = 0;
      check("swap_buf", buf_sel, 1);
      fetch(19'd153600, 36'h222222222);
      frame_flag = 1; frame_start = 1; step(); frame_flag = 0; frame_start = 0;
      check("swap_same_cycle", buf_sel, 0);
      fetch(19'd0, 36'h333333333);
      // blanked pair
      vga_flag = 1; pixel_active = 0;
      step();
      vga_flag = 0;
      check("blank_req", mem_req, 0);
      check("blank_done_early", done_vga, 0);
      step();
      check("blank_done", done_vga, 1);
      check("blank_pixel", vga_pixel, 0);
      check("blank_req2", mem_req, 0);
      step();
      check("blank_done_clear", done_vga, 0);
      fetch(19'd1, 36'h444444444);
      // second flag during WAIT is dropped
      check("underrun_pre", underrun, 0);
      vga_flag = 1; pixel_active = 1; mem_grant = 1; mem_rdata = 36'h555555555;
      step();
      vga_flag = 0;
      check("ur_addr", mem_addr, 2);
      step();
      vga_flag = 1;
      step();
      vga_flag = 0;
      check("underrun_set", underrun, 1);
      step();
      check("ur_done", done_vga, 1);
      check("ur_pixel", vga_pixel, 36'h555555555);
      for (int i = 0; i < 5; i++) begin
         step();
         check("ur_single_done", done_vga, 0);
         check("ur_no_req", mem_req, 0);
      end
      check("underrun_sticky", underrun, 1);
      // reset while in REQ
      vga_flag = 1; mem_grant = 0;
      step();
      vga_flag = 0;
      check("rreq_req", mem_req, 1);
      reset = 1;
      step();
      reset = 0; mem_grant = 1;
      check("rreq_req_drop", mem_req, 0);
      for (int i = 0; i < 5; i++) begin
         check("rreq_no_done", done_vga, 0);
         step();
      end
      check("rreq_underrun", underrun, 0);
      check("rreq_pixel", vga_pixel, 0);
      fetch(19'd0, 36'h666666666);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Memory-side responder for the VGA scan-out writer. It answers each `vga_flag` request pulse by reading one 36-bit word (two 18-bit pixels) from the ZBT frame store. It returns that word on `vga_pixel` and pulses `done_vga`.
- Tracks the scan-out address inside the current display frame and selects between two frame buffers.
- Buffer swap happens only at frame start, so the display never tears.
- Sits between the VGA writer and the ZBT memory arbiter, in the system `clock` domain.

Parameters:
- MEM_W, 36, memory word width; must equal `LOG_MEM`.
- ADDR_W, 19, memory address width.
- WORDS_PER_FRAME, 153600, words per displayed frame (640*480/2).
- BASE_0, 0, word address of frame buffer 0.
- BASE_1, 153600, word address of frame buffer 1.
- READ_LAT, 2, cycles from granted request edge to valid `mem_rdata`; legal range 1..4.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- vga_flag  in  1  one-cycle request pulse from the VGA writer, one per pixel pair.
- pixel_active  in  1  sampled with `vga_flag`; 1 = pair lies in the visible region.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- frame_flag  in  1  one-cycle pulse from processing: back buffer is complete.
- vga_pixel  out  MEM_W  returned word (registered, held between updates).
- done_vga  out  1  one-cycle pulse: `vga_pixel` has just been updated.
- mem_req  out  1  read request to arbiter.
- mem_addr  out  ADDR_W  read address, valid while `mem_req`.
- mem_grant  in  1  arbiter accepts the request on the edge where `mem_req` & `mem_grant`.
- mem_rdata  in  MEM_W  read data, valid READ_LAT edges after the grant edge.
- buf_sel  out  1  frame buffer currently displayed.
- underrun  out  1  sticky: a `vga_flag` arrived while a fetch was outstanding.

Behaviour:
- Reset: all outputs are 0 (`vga_pixel`, `done_vga`, `mem_req`, `mem_addr`, `buf_sel`, `underrun`); offset = 0; `swap_pending` = 0; state = IDLE. Reset mid-fetch abandons the fetch; late `mem_rdata` is ignored.
- FSM states: IDLE, REQ, WAIT, BLANK.
- IDLE:
  - `vga_flag` & `pixel_active` -> REQ, with `mem_req` = 1 and `mem_addr` = (`buf_sel` ? BASE_1 : BASE_0) + offset, both registered at the next edge.
  - `vga_flag` & ~`pixel_active` -> BLANK.
- BLANK: no memory access; `vga_pixel` <= 0 and `done_vga` = 1 in the following cycle; -> IDLE.
- REQ:
  - Hold `mem_req` and `mem_addr` stable until the grant edge.
  - On the grant edge: `mem_req` <= 0; latency counter <= READ_LAT-1; -> WAIT.
  - With no grant, stay in REQ indefinitely.
- WAIT:
  - Count down; when the counter is 0, capture `vga_pixel` <= `mem_rdata` on the edge exactly READ_LAT after the grant edge.
  - `done_vga` = 1 for the cycle after that edge.
  - Offset advances; -> IDLE.
- Latency: flag at edge t, immediate grant at t+1 -> `vga_pixel` valid after edge t+1+READ_LAT, with `done_vga` high in that cycle.
- Offset: increments by 1 per completed active fetch. At WORDS_PER_FRAME-1 it wraps to 0.
- `frame_flag` sets `swap_pending`.
- `frame_start`:
  - offset <= 0.
  - If `swap_pending` (including a `frame_flag` in the same cycle): `buf_sel` toggles and `swap_pending` clears.
  - `frame_start` has priority over a same-cycle offset increment.
  - An outstanding fetch completes normally with its already-issued address.
- `vga_flag` while not IDLE (REQ/WAIT/BLANK): the request is dropped, not queued; `underrun` <= 1. It clears only on reset.
- `vga_flag` in the same cycle `done_vga` is high is accepted (FSM is IDLE).
- `mem_addr` holds its last value when `mem_req` = 0.

Test Plan:
- Reset, then `vga_flag` + `pixel_active` with `mem_grant` tied 1, READ_LAT = 2, `mem_rdata` = 36'h123456789 -> `mem_req` high 1 cycle at `mem_addr` 0; `vga_pixel` = 36'h123456789 with `done_vga` exactly 3 edges after the flag edge.
- Grant withheld 5 cycles -> `mem_addr` stable for all 5 cycles; data captured READ_LAT edges after the actual grant; offset 0 -> 1.
- 153600 active fetches, then one more -> `mem_addr` wraps from 153599 back to 0.
- `frame_flag`, then `frame_start` -> `buf_sel` = 1, next fetch at `mem_addr` 153600. `frame_start` alone -> `buf_sel` unchanged, offset reset to 0.
- `vga_flag` with `pixel_active` = 0 -> no `mem_req`; `vga_pixel` = 0, `done_vga` pulse 1 cycle later; offset unchanged.
- Second `vga_flag` during WAIT -> `underrun` = 1 and stays 1; only one `done_vga` pulse. Reset during REQ -> `mem_req` = 0 next edge; no `done_vga`.
